// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave memory with independent read and write burst
// engines (one transaction each), FIXED/INCR/WRAP bursts, byte strobes and
// OKAY/SLVERR/DECERR responses. Array contents survive reset.
module axi_mem_responder #(
  parameter int          MEM_AW = 10,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic        host_clk,
  input  logic        host_rst_n,
  // write address
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awid,
  input  logic [7:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  // write data
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  // write response
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bid,
  // read address
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arid,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  // read data
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rid,
  output logic        s_axi_rlast
);

  localparam int DEPTH = 1 << MEM_AW;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic f_in_range(input logic [31:0] a);
    return (a >> (MEM_AW + 2)) == (BASE >> (MEM_AW + 2));
  endfunction

  function automatic logic f_wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  function automatic logic f_perr(input logic [2:0] size, input logic [1:0] burst,
                                  input logic [7:0] len);
    return (size > 3'd2) || (burst == BURST_RSVD) ||
           ((burst == BURST_WRAP) && !f_wrap_len_ok(len));
  endfunction

  // Oversized beats step as 4 bytes; reserved burst and illegal WRAP step as INCR.
  function automatic logic [31:0] f_next(input logic [31:0] addr, input logic [2:0] size,
                                         input logic [7:0] len, input logic [1:0] burst);
    logic [1:0]  sz;
    logic [31:0] step;
    logic [31:0] mask;
    sz   = (size > 3'd2) ? 2'd2 : size[1:0];
    step = 32'd1 << sz;
    mask = (({24'd0, len} + 32'd1) << sz) - 32'd1;
    if (burst == BURST_FIXED)
      return addr;
    else if ((burst == BURST_WRAP) && f_wrap_len_ok(len))
      return (addr & ~mask) | ((addr + step) & mask);
    else
      return addr + step;
  endfunction

  // ---------------------------------------------------------------------------
  // Storage and common state
  // ---------------------------------------------------------------------------
  logic [31:0] r_mem [DEPTH];
  logic        r_live;

  // Ready outputs stay low until the first clock after reset release.
  always_ff @(posedge host_clk or negedge host_rst_n) begin
    if (!host_rst_n) r_live <= 1'b0;
    else             r_live <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Write engine
  // ---------------------------------------------------------------------------
  w_state_t    r_w_state, w_w_state_nxt;
  logic [31:0] r_w_addr;
  logic        r_w_id;
  logic [7:0]  r_w_len;
  logic [2:0]  r_w_size;
  logic [1:0]  r_w_burst;
  logic [7:0]  r_w_beat;
  logic        r_w_over;   // beat number len already accepted; later beats dropped
  logic        r_w_dec;
  logic        r_w_perr;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_w_en;
  logic [MEM_AW-1:0] w_w_idx;

  assign w_aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_w_hs  = s_axi_wvalid & s_axi_wready;
  assign w_w_idx = r_w_addr[MEM_AW+1:2];
  assign w_w_en  = w_w_hs && !r_w_over && f_in_range(r_w_addr);

  // Write FSM state register.
  always_ff @(posedge host_clk or negedge host_rst_n) begin
    if (!host_rst_n) r_w_state <= W_IDLE;
    else             r_w_state <= w_w_state_nxt;
  end

  // Write FSM next state and handshake outputs.
  always_comb begin
    w_w_state_nxt = r_w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (r_w_state)
      W_IDLE: begin
        s_axi_awready = r_live;
        if (s_axi_awvalid && r_live) w_w_state_nxt = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && s_axi_wlast) w_w_state_nxt = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_w_state_nxt = W_IDLE;
      end
      default: w_w_state_nxt = W_IDLE;
    endcase
  end

  // Write request latch, beat tracking, address stepping and error accumulation.
  always_ff @(posedge host_clk or negedge host_rst_n) begin
    if (!host_rst_n) begin
      r_w_addr  <= '0;
      r_w_id    <= 1'b0;
      r_w_len   <= '0;
      r_w_size  <= '0;
      r_w_burst <= '0;
      r_w_beat  <= '0;
      r_w_over  <= 1'b0;
      r_w_dec   <= 1'b0;
      r_w_perr  <= 1'b0;
    end else if (w_aw_hs) begin
      r_w_addr  <= s_axi_awaddr;
      r_w_id    <= s_axi_awid;
      r_w_len   <= s_axi_awlen;
      r_w_size  <= s_axi_awsize;
      r_w_burst <= s_axi_awburst;
      r_w_beat  <= '0;
      r_w_over  <= 1'b0;
      r_w_dec   <= 1'b0;
      r_w_perr  <= f_perr(s_axi_awsize, s_axi_awburst, s_axi_awlen);
    end else if (w_w_hs) begin
      if (!r_w_over && !f_in_range(r_w_addr)) r_w_dec <= 1'b1;
      if (s_axi_wlast && (r_w_over || (r_w_beat != r_w_len))) r_w_perr <= 1'b1;
      if (r_w_beat == r_w_len) r_w_over <= 1'b1;
      if (r_w_beat != 8'hFF) r_w_beat <= r_w_beat + 8'd1;
      r_w_addr <= f_next(r_w_addr, r_w_size, r_w_len, r_w_burst);
    end
  end

  // Strobed array write; no reset so contents survive an abandoned burst.
  always_ff @(posedge host_clk) begin
    if (w_w_en) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi_wstrb[b]) r_mem[w_w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  assign s_axi_bresp = (r_w_state != W_RESP) ? RESP_OKAY   :
                       r_w_dec                ? RESP_DECERR :
                       r_w_perr               ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_bid   = r_w_id;

  // ---------------------------------------------------------------------------
  // Read engine
  // ---------------------------------------------------------------------------
  r_state_t    r_r_state, w_r_state_nxt;
  logic [31:0] r_r_addr;
  logic        r_r_id;
  logic [7:0]  r_r_len;
  logic [2:0]  r_r_size;
  logic [1:0]  r_r_burst;
  logic [7:0]  r_r_beat;
  logic        r_r_perr;
  logic [31:0] r_r_data;
  logic [1:0]  r_r_resp;

  logic        w_ar_hs;
  logic        w_r_hs;
  logic [31:0] w_r_next;
  logic [31:0] w_r_ld_addr;
  logic        w_r_ld_perr;
  logic        w_r_ld_in;

  assign w_ar_hs     = s_axi_arvalid & s_axi_arready;
  assign w_r_hs      = s_axi_rvalid & s_axi_rready;
  assign w_r_next    = f_next(r_r_addr, r_r_size, r_r_len, r_r_burst);
  assign w_r_ld_addr = w_ar_hs ? s_axi_araddr : w_r_next;
  assign w_r_ld_perr = w_ar_hs ? f_perr(s_axi_arsize, s_axi_arburst, s_axi_arlen) : r_r_perr;
  assign w_r_ld_in   = f_in_range(w_r_ld_addr);

  // Read FSM state register.
  always_ff @(posedge host_clk or negedge host_rst_n) begin
    if (!host_rst_n) r_r_state <= R_IDLE;
    else             r_r_state <= w_r_state_nxt;
  end

  // Read FSM next state and handshake outputs.
  always_comb begin
    w_r_state_nxt = r_r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    case (r_r_state)
      R_IDLE: begin
        s_axi_arready = r_live;
        if (s_axi_arvalid && r_live) w_r_state_nxt = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        s_axi_rlast  = (r_r_beat == r_r_len);
        if (s_axi_rready && (r_r_beat == r_r_len)) w_r_state_nxt = R_IDLE;
      end
      default: w_r_state_nxt = R_IDLE;
    endcase
  end

  // Read request latch and per-beat prefetch of data and response.
  always_ff @(posedge host_clk or negedge host_rst_n) begin
    if (!host_rst_n) begin
      r_r_addr  <= '0;
      r_r_id    <= 1'b0;
      r_r_len   <= '0;
      r_r_size  <= '0;
      r_r_burst <= '0;
      r_r_beat  <= '0;
      r_r_perr  <= 1'b0;
      r_r_data  <= '0;
      r_r_resp  <= RESP_OKAY;
    end else if (w_ar_hs || (w_r_hs && !s_axi_rlast)) begin
      if (w_ar_hs) begin
        r_r_id    <= s_axi_arid;
        r_r_len   <= s_axi_arlen;
        r_r_size  <= s_axi_arsize;
        r_r_burst <= s_axi_arburst;
        r_r_beat  <= '0;
        r_r_perr  <= w_r_ld_perr;
      end else if (r_r_beat != 8'hFF) begin
        r_r_beat  <= r_r_beat + 8'd1;
      end
      r_r_addr <= w_r_ld_addr;
      if (!w_r_ld_in) begin
        r_r_data <= '0;
        r_r_resp <= RESP_DECERR;
      end else begin
        r_r_data <= r_mem[w_r_ld_addr[MEM_AW+1:2]];
        r_r_resp <= w_r_ld_perr ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign s_axi_rdata = r_r_data;
  assign s_axi_rresp = r_r_resp;
  assign s_axi_rid   = r_r_id;

endmodule
